// File: rtl/dm_wb_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with a req/ack line memory port.
// Optional performance counters are enabled by defining DM_CACHE_PERF_CNT_EN.
module dm_wb_cache_ctrl #(
  parameter  int ADDR_W         = 32,
  parameter  int WORD_W         = 32,
  parameter  int LINES          = 4,
  parameter  int WORDS_PER_LINE = 4,
  localparam int OFF_W          = $clog2(WORDS_PER_LINE),
  localparam int IDX_W          = $clog2(LINES),
  localparam int TAG_W          = ADDR_W - IDX_W - OFF_W,
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DM_CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses,
  output logic [31:0]       perf_writebacks
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_RESPOND} state_t;

  state_t            r_state;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_is_write;

  logic [TAG_W-1:0]  w_req_tag, w_lat_tag;
  logic [IDX_W-1:0]  w_req_idx, w_lat_idx, w_line_idx;
  logic [OFF_W-1:0]  w_req_off, w_lat_off;
  logic              w_req_valid, w_req_write, w_hit, w_accept, w_refill_done, w_line_we;
  logic [LINE_W-1:0] w_cur_line, w_line_new;
  logic [WORD_W-1:0] w_hit_word, w_refill_word;

  assign w_req_tag     = cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_req_idx     = cpu_addr[OFF_W +: IDX_W];
  assign w_req_off     = cpu_addr[OFF_W-1:0];
  assign w_lat_tag     = r_addr[ADDR_W-1 -: TAG_W];
  assign w_lat_idx     = r_addr[OFF_W +: IDX_W];
  assign w_lat_off     = r_addr[OFF_W-1:0];
  // A simultaneous read and write is served as a plain read.
  assign w_req_valid   = cpu_read | cpu_write;
  assign w_req_write   = cpu_write & ~cpu_read;
  assign w_hit         = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_accept      = (r_state == S_IDLE) && w_req_valid;
  assign w_refill_done = (r_state == S_REFILL) && mem_ack;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cur_line    = r_data[w_req_idx];
    w_hit_word    = w_cur_line[int'(w_req_off)*WORD_W +: WORD_W];
    w_line_we     = 1'b0;
    w_line_idx    = w_req_idx;
    w_line_new    = w_cur_line;
    w_refill_word = '0;
    if (w_accept && w_hit && w_req_write) begin
      w_line_we = 1'b1;
      w_line_new[int'(w_req_off)*WORD_W +: WORD_W] = cpu_wdata;
    end else if (w_refill_done) begin
      w_line_we  = 1'b1;
      w_line_idx = w_lat_idx;
      w_line_new = mem_rdata;
      if (r_is_write) begin
        w_line_new[int'(w_lat_off)*WORD_W +: WORD_W] = r_wdata;
      end
      w_refill_word = w_line_new[int'(w_lat_off)*WORD_W +: WORD_W];
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (w_line_we) begin
      r_data[w_line_idx] <= w_line_new;
    end
    if (w_refill_done) begin
      r_tag[w_lat_idx] <= w_lat_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      cpu_ready  <= 1'b0;
      hit        <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_valid) begin
            r_addr     <= cpu_addr;
            r_wdata    <= cpu_wdata;
            r_is_write <= w_req_write;
            if (w_hit) begin
              r_state   <= S_RESPOND;
              cpu_ready <= 1'b1;
              hit       <= 1'b1;
              cpu_rdata <= w_req_write ? cpu_wdata : w_hit_word;
              if (w_req_write) begin
                r_dirty[w_req_idx] <= 1'b1;
              end
            end else if (r_valid[w_req_idx] && r_dirty[w_req_idx]) begin
              r_state   <= S_WRITEBACK;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {r_tag[w_req_idx], w_req_idx, {OFF_W{1'b0}}};
              mem_wdata <= w_cur_line;
            end else begin
              r_state  <= S_REFILL;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {w_req_tag, w_req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ack) begin
            r_state  <= S_REFILL;
            mem_we   <= 1'b0;
            mem_addr <= {w_lat_tag, w_lat_idx, {OFF_W{1'b0}}};
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            r_state            <= S_RESPOND;
            mem_req            <= 1'b0;
            r_valid[w_lat_idx] <= 1'b1;
            r_dirty[w_lat_idx] <= r_is_write;
            cpu_ready          <= 1'b1;
            hit                <= 1'b0;
            cpu_rdata          <= w_refill_word;
          end
        end
        S_RESPOND: begin
          r_state   <= S_IDLE;
          cpu_ready <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DM_CACHE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_hits       <= '0;
      perf_misses     <= '0;
      perf_writebacks <= '0;
    end else begin
      if (w_accept && w_hit) perf_hits <= sat_inc(perf_hits);
      if (w_refill_done) perf_misses <= sat_inc(perf_misses);
      if ((r_state == S_WRITEBACK) && mem_ack) perf_writebacks <= sat_inc(perf_writebacks);
    end
  end
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_dm_wb_cache_ctrl.sv
// Self-checking bench for dm_wb_cache_ctrl: directed vector table, reset/ack corner cases,
// then random traffic checked against a flat-memory reference model.
module tb_dm_wb_cache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  cpu_addr;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_ready, hit, mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef DM_CACHE_PERF_CNT_EN
  logic [31:0]  perf_hits, perf_misses, perf_writebacks;
`endif

  always #5 clk = ~clk;

  dm_wb_cache_ctrl dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DM_CACHE_PERF_CNT_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_writebacks(perf_writebacks)
`endif
  );

  // Backing memory, plus the word values the CPU should observe at every address.
  logic [31:0] mem_words [256];
  logic [31:0] ref_view  [256];
  bit          ref_valid [4];
  bit          ref_dirty [4];
  logic [27:0] ref_tag   [4];
  int          exp_hits, exp_misses, exp_wbs;

  int           errors = 0;
  int           checks = 0;
  int           wb_n = 0, rf_n = 0, wait_cnt = 0;
  bit           resp_en = 1'b1;
  logic [31:0]  last_wb_addr, last_rf_addr;
  logic [127:0] last_wb_data;

  typedef struct {
    logic [31:0] addr;
    bit          rd, wr;
    logic [31:0] wdata, e_rdata;
    bit          e_hit;
    int          e_wb, e_rf;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One negedge worth of memory-side behaviour: drop a pending ack, or answer a request.
  task automatic mem_step();
    int base;
    logic [127:0] line;
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req && resp_en) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        check("mem_addr_aligned", mem_addr[1:0], 2'b00);
        base = int'(mem_addr[7:0]);
        if (mem_we) begin
          for (int w = 0; w < 4; w++) line[w*32 +: 32] = ref_view[base + w];
          check("wb_data", mem_wdata, line);
          for (int w = 0; w < 4; w++) mem_words[base + w] = mem_wdata[w*32 +: 32];
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
          wb_n++;
        end else begin
          for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = mem_words[base + w];
          last_rf_addr = mem_addr;
          rf_n++;
        end
        mem_ack  = 1'b1;
        wait_cnt = $urandom_range(0, 3);
      end
    end
  endtask

  // Reference: direct-mapped residency tracked per index, data as a flat word array.
  task automatic model_access(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                              output logic [31:0] e_rdata, output bit e_hit, output int e_wb,
                              output int e_rf);
    int   idx;
    bit   is_w;
    idx   = int'(a[3:2]);
    is_w  = wr && !rd;
    e_hit = ref_valid[idx] && (ref_tag[idx] == a[31:4]);
    e_wb  = (!e_hit && ref_valid[idx] && ref_dirty[idx]) ? 1 : 0;
    e_rf  = e_hit ? 0 : 1;
    if (is_w) begin
      e_rdata = wd;
      ref_view[a[7:0]] = wd;
    end else begin
      e_rdata = ref_view[a[7:0]];
    end
    if (!e_hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = a[31:4];
      ref_dirty[idx] = 1'b0;
    end
    if (is_w) ref_dirty[idx] = 1'b1;
    exp_hits   += e_hit ? 1 : 0;
    exp_misses += e_hit ? 0 : 1;
    exp_wbs    += e_wb;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) ref_view[i] = mem_words[i];
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
  endtask

  task automatic access(input string nm, input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] wd, input logic [31:0] e_rdata, input bit e_hit,
                        input int e_wb, input int e_rf);
    int wb0, rf0, cyc;
    bit got, req_seen;
    logic [31:0] rdata;
    logic h;
    wb0 = wb_n; rf0 = rf_n; got = 1'b0; req_seen = 1'b0; cyc = 0;
    cpu_addr = a; cpu_read = rd; cpu_write = wr; cpu_wdata = wd;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (mem_req) req_seen = 1'b1;
      mem_step();
      if (cpu_ready) begin
        got = 1'b1;
        cyc = c;
        break;
      end
    end
    rdata = cpu_rdata;
    h     = hit;
    cpu_read = 1'b0; cpu_write = 1'b0;
    check({nm, ":ready"}, got, 1'b1);
    check({nm, ":rdata"}, rdata, e_rdata);
    check({nm, ":hit"}, h, e_hit);
    check({nm, ":writebacks"}, wb_n - wb0, e_wb);
    check({nm, ":refills"}, rf_n - rf0, e_rf);
    check({nm, ":mem_req_seen"}, req_seen, !e_hit);
    if (e_hit) check({nm, ":hit_latency"}, cyc, 1);
    @(negedge clk);
    mem_step();
    check({nm, ":ready_pulse"}, cpu_ready, 1'b0);
  endtask

  task automatic modeled_access(input string nm, input logic [31:0] a, input bit rd, input bit wr,
                                input logic [31:0] wd);
    logic [31:0] e_rdata;
    bit e_hit;
    int e_wb, e_rf;
    model_access(a, rd, wr, wd, e_rdata, e_hit, e_wb, e_rf);
    access(nm, a, rd, wr, wd, e_rdata, e_hit, e_wb, e_rf);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d0, d1;
    bit b0;
    int i0, i1, op;
    logic [31:0] ra;

    vecs[0]  = '{32'h05, 1, 0, 32'h0,        32'h11,        0, 0, 1};
    vecs[1]  = '{32'h05, 1, 0, 32'h0,        32'h11,        1, 0, 0};
    vecs[2]  = '{32'h06, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF,  1, 0, 0};
    vecs[3]  = '{32'h06, 1, 0, 32'h0,        32'hDEADBEEF,  1, 0, 0};
    vecs[4]  = '{32'h15, 1, 0, 32'h0,        32'hA5000015,  0, 1, 1};
    vecs[5]  = '{32'h28, 0, 1, 32'hCAFE0028, 32'hCAFE0028,  0, 0, 1};
    vecs[6]  = '{32'h28, 1, 0, 32'h0,        32'hCAFE0028,  1, 0, 0};
    vecs[7]  = '{32'h29, 1, 0, 32'h0,        32'hA5000029,  1, 0, 0};
    vecs[8]  = '{32'h05, 1, 0, 32'h0,        32'h11,        0, 0, 1};
    vecs[9]  = '{32'h05, 1, 1, 32'hFFFFFFFF, 32'h11,        1, 0, 0};
    vecs[10] = '{32'h05, 1, 0, 32'h0,        32'h11,        1, 0, 0};

    for (int i = 0; i < 256; i++) mem_words[i] = 32'hA500_0000 | i;
    mem_words[4] = 32'h00; mem_words[5] = 32'h11; mem_words[6] = 32'h22; mem_words[7] = 32'h33;

    reset = 1'b0; cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset:cpu_ready", cpu_ready, 1'b0);
    check("reset:hit", hit, 1'b0);
    check("reset:cpu_rdata", cpu_rdata, 32'h0);
    check("reset:mem_req", mem_req, 1'b0);
    check("reset:mem_we", mem_we, 1'b0);
    check("reset:mem_addr", mem_addr, 32'h0);
    check("reset:mem_wdata", mem_wdata, 128'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      model_access(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, d0, b0, i0, i1);
      access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata,
             vecs[i].e_rdata, vecs[i].e_hit, vecs[i].e_wb, vecs[i].e_rf);
      if (i == 4) begin
        check("vec4:wb_addr", last_wb_addr, 32'h4);
        check("vec4:wb_word2", last_wb_data[95:64], 32'hDEADBEEF);
        check("vec4:rf_addr", last_rf_addr, 32'h14);
`ifdef DM_CACHE_PERF_CNT_EN
        check("vec4:perf_writebacks", perf_writebacks, 32'd1);
`endif
      end
    end

    // Reset asserted in the middle of a refill that memory never acknowledges.
    resp_en  = 1'b0;
    cpu_addr = 32'h45; cpu_read = 1'b1;
    repeat (3) @(negedge clk);
    check("abort:mem_req_before", mem_req, 1'b1);
    check("abort:mem_we_before", mem_we, 1'b0);
    check("abort:mem_addr_before", mem_addr, 32'h44);
    reset = 1'b0;
    #1;
    check("abort:mem_req_after", mem_req, 1'b0);
    check("abort:cpu_ready_after", cpu_ready, 1'b0);
    check("abort:mem_addr_after", mem_addr, 32'h0);
    cpu_read = 1'b0;
    @(negedge clk);
    reset = 1'b1; resp_en = 1'b1; wait_cnt = 0;
    model_reset();
    @(negedge clk);
    access("post_reset_read", 32'h05, 1, 0, 32'h0, 32'h11, 0, 0, 1);
    model_access(32'h05, 1, 0, 32'h0, d0, b0, i0, i1);

    // An acknowledge with no outstanding request must do nothing.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack:mem_req", mem_req, 1'b0);
    check("stray_ack:cpu_ready", cpu_ready, 1'b0);
    modeled_access("after_stray_ack", 32'h05, 1, 0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      ra = 32'($urandom_range(0, 127));
      op = $urandom_range(0, 9);
      d1 = $urandom;
      modeled_access($sformatf("rand%0d", n), ra, (op < 5) || (op == 9), op >= 5, d1);
    end

`ifdef DM_CACHE_PERF_CNT_EN
    check("perf_hits", perf_hits, 32'(exp_hits));
    check("perf_misses", perf_misses, 32'(exp_misses));
    check("perf_writebacks", perf_writebacks, 32'(exp_wbs));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
